// File: rtl/spi_slave_if.sv
// rtl/spi_slave_if.sv - SPI slave bus bundle: serial pins plus RAM-side word/byte handshake
// Signals:
//   SS_n     master -> slave  slave select, active low, frames one transaction
//   MOSI     master -> slave  serial data in, MSB first
//   MISO     slave -> master  serial read data out, MSB first, registered
//   rx_data  slave -> RAM     assembled word: [9:8] command, [7:0] address/data
//   rx_valid slave -> RAM     one-cycle strobe marking rx_data valid
//   tx_data  RAM -> slave     read data byte
//   tx_valid RAM -> slave     tx_data valid strobe
interface spi_slave_if;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    modport slave (
        input  SS_n, MOSI, tx_data, tx_valid,
        output MISO, rx_data, rx_valid
    );

    modport master (
        output SS_n, MOSI, tx_data, tx_valid,
        input  MISO, rx_data, rx_valid
    );
endinterface

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI slave: 10-bit command/address/data word in, 8-bit read data out
// Ports:
//   clk    system clock, all state changes on the rising edge
//   rst_n  asynchronous active-low reset
//   bus    spi_slave_if.slave (SS_n, MOSI, MISO, rx_data, rx_valid, tx_data, tx_valid)
module spi_slave (
    input  logic        clk,
    input  logic        rst_n,
    spi_slave_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_t;

    state_t     state, state_next;
    logic [3:0] bit_cnt;
    logic [8:0] shift_reg;
    logic       word_done;
    logic       rd_addr_received;
    logic [7:0] tx_shift;
    logic [3:0] tx_cnt;
    logic       tx_active;
    logic       tx_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!bus.SS_n) state_next = CHK_CMD;
            end
            CHK_CMD: begin
                if (bus.SS_n)           state_next = IDLE;
                else if (!bus.MOSI)     state_next = WRITE;
                else if (rd_addr_received) state_next = READ_DATA;
                else                    state_next = READ_ADD;
            end
            WRITE, READ_ADD, READ_DATA: begin
                if (bus.SS_n) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath. Slave-select high (or sitting in IDLE) clears every per-frame
    // register, so an aborted frame leaves nothing behind except rx_data and
    // rd_addr_received, which only move on a completed word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.MISO         <= 1'b0;
            bus.rx_data      <= 10'h000;
            bus.rx_valid     <= 1'b0;
            bit_cnt          <= 4'd0;
            shift_reg        <= 9'd0;
            word_done        <= 1'b0;
            rd_addr_received <= 1'b0;
            tx_shift         <= 8'd0;
            tx_cnt           <= 4'd0;
            tx_active        <= 1'b0;
            tx_done          <= 1'b0;
        end else begin
            bus.rx_valid <= 1'b0;
            if (bus.SS_n || state == IDLE) begin
                bus.MISO  <= 1'b0;
                bit_cnt   <= 4'd0;
                shift_reg <= 9'd0;
                word_done <= 1'b0;
                tx_shift  <= 8'd0;
                tx_cnt    <= 4'd0;
                tx_active <= 1'b0;
                tx_done   <= 1'b0;
            end else if (state == CHK_CMD) begin
                // Command bit 9 seeds the shift register.
                shift_reg <= {8'd0, bus.MOSI};
                bit_cnt   <= 4'd0;
            end else if (!word_done) begin
                if (bit_cnt == 4'd8) begin
                    bus.rx_data  <= {shift_reg, bus.MOSI};
                    bus.rx_valid <= 1'b1;
                    word_done    <= 1'b1;
                    if (state == READ_ADD)  rd_addr_received <= 1'b1;
                    if (state == READ_DATA) rd_addr_received <= 1'b0;
                end else begin
                    shift_reg <= {shift_reg[7:0], bus.MOSI};
                    bit_cnt   <= bit_cnt + 4'd1;
                end
            end else if (state == READ_DATA && !tx_done) begin
                // Wait for tx_valid, then eight MISO bits, then park at 0.
                if (!tx_active) begin
                    if (bus.tx_valid) begin
                        tx_shift  <= bus.tx_data;
                        tx_cnt    <= 4'd0;
                        tx_active <= 1'b1;
                    end
                end else if (tx_cnt == 4'd8) begin
                    bus.MISO  <= 1'b0;
                    tx_active <= 1'b0;
                    tx_done   <= 1'b1;
                end else begin
                    bus.MISO <= tx_shift[7];
                    tx_shift <= {tx_shift[6:0], 1'b0};
                    tx_cnt   <= tx_cnt + 4'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - directed self-checking bench for spi_slave
module tb_spi_slave;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    spi_slave_if bus ();

    spi_slave dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One rising edge; inputs are driven and outputs sampled on the falling edge.
    task automatic tick;
        @(negedge clk);
    endtask

    // Full frame: select edge, then bits 9..0; checks the single rx_valid pulse.
    task automatic frame(input string tag, input logic [9:0] word);
        logic [9:0] w;
        w = word;
        bus.SS_n = 1'b0;
        tick();
        for (int i = 9; i >= 0; i--) begin
            bus.MOSI = w[i];
            tick();
            if (i != 0) chk({tag, "_no_early_valid"}, {31'd0, bus.rx_valid}, 32'd0);
        end
        chk({tag, "_rx_valid"}, {31'd0, bus.rx_valid}, 32'd1);
        chk({tag, "_rx_data"}, {22'd0, bus.rx_data}, {22'd0, w});
        chk({tag, "_miso"}, {31'd0, bus.MISO}, 32'd0);
    endtask

    initial begin
        logic [7:0] b;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.SS_n = 1'b1;
        bus.MOSI = 1'b0;
        bus.tx_data = 8'h00;
        bus.tx_valid = 1'b0;
        tick();
        tick();
        chk("rst_miso", {31'd0, bus.MISO}, 32'd0);
        chk("rst_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
        chk("rst_rx_data", {22'd0, bus.rx_data}, 32'h000);
        chk("rst_rd_addr", {31'd0, dut.rd_addr_received}, 32'd0);
        chk("rst_state", {29'd0, dut.state}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_hold", {29'd0, dut.state}, 32'd0);

        // Read command with no stored address goes to READ_ADD; abort keeps flag clear.
        bus.SS_n = 1'b0;
        tick();
        chk("chk_cmd", {29'd0, dut.state}, 32'd1);
        bus.MOSI = 1'b1;
        tick();
        chk("no_addr_read_add", {29'd0, dut.state}, 32'd3);
        bus.SS_n = 1'b1;
        tick();
        chk("abort_idle", {29'd0, dut.state}, 32'd0);
        chk("abort_rd_addr", {31'd0, dut.rd_addr_received}, 32'd0);

        // Write address.
        frame("wr_addr", 10'h055);
        tick();
        chk("wr_addr_pulse_one", {31'd0, bus.rx_valid}, 32'd0);
        chk("wr_addr_hold", {22'd0, bus.rx_data}, 32'h055);
        bus.SS_n = 1'b1;
        tick();

        // Write data, then back to IDLE.
        frame("wr_data", 10'h1A5);
        chk("wr_data_state", {29'd0, dut.state}, 32'd2);
        bus.SS_n = 1'b1;
        tick();
        chk("wr_data_idle", {29'd0, dut.state}, 32'd0);

        // Read address; extra MOSI after completion must not produce a word.
        frame("rd_addr", 10'h233);
        chk("rd_addr_flag", {31'd0, dut.rd_addr_received}, 32'd1);
        chk("rd_addr_state", {29'd0, dut.state}, 32'd3);
        bus.MOSI = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("rd_addr_ignore", {31'd0, bus.rx_valid}, 32'd0);
        end
        bus.SS_n = 1'b1;
        tick();

        // Read data: tx_valid two cycles later, byte C3 out MSB first.
        frame("rd_data", 10'h300);
        chk("rd_data_state", {29'd0, dut.state}, 32'd4);
        chk("rd_data_flag_clr", {31'd0, dut.rd_addr_received}, 32'd0);
        tick();
        tick();
        chk("wait_miso", {31'd0, bus.MISO}, 32'd0);
        bus.tx_data = 8'hC3;
        bus.tx_valid = 1'b1;
        tick();
        chk("latch_miso", {31'd0, bus.MISO}, 32'd0);
        bus.tx_data = 8'h00;  // held tx_valid with new data must not reload
        b = 8'hC3;
        for (int i = 7; i >= 0; i--) begin
            tick();
            chk("shift_c3", {31'd0, bus.MISO}, {31'd0, b[i]});
        end
        tick();
        chk("post_shift_0", {31'd0, bus.MISO}, 32'd0);
        tick();
        tick();
        chk("post_shift_hold", {31'd0, bus.MISO}, 32'd0);
        bus.tx_valid = 1'b0;
        bus.SS_n = 1'b1;
        tick();
        chk("rd_idle", {29'd0, dut.state}, 32'd0);

        // Abort after 6 bits, then a clean 0FF frame.
        bus.SS_n = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) begin
            bus.MOSI = i[0];
            tick();
        end
        bus.SS_n = 1'b1;
        tick();
        chk("abort6_valid", {31'd0, bus.rx_valid}, 32'd0);
        chk("abort6_idle", {29'd0, dut.state}, 32'd0);
        frame("after_abort", 10'h0FF);
        bus.SS_n = 1'b1;
        tick();

        // SS_n rises on the 10th bit edge: no word.
        bus.SS_n = 1'b0;
        tick();
        for (int i = 0; i < 9; i++) begin
            bus.MOSI = 1'b1;
            tick();
        end
        bus.MOSI = 1'b0;
        bus.SS_n = 1'b1;
        tick();
        chk("abort10_valid", {31'd0, bus.rx_valid}, 32'd0);
        chk("abort10_hold", {22'd0, bus.rx_data}, 32'h0FF);
        chk("abort10_idle", {29'd0, dut.state}, 32'd0);

        // Async reset during shift-out after 3 bits of A5.
        frame("rst_rd_addr", 10'h233);
        bus.SS_n = 1'b1;
        tick();
        frame("rst_rd_data", 10'h300);
        bus.tx_data = 8'hA5;
        bus.tx_valid = 1'b1;
        tick();
        bus.tx_valid = 1'b0;
        b = 8'hA5;
        for (int i = 7; i >= 5; i--) begin
            tick();
            chk("rst_shift_a5", {31'd0, bus.MISO}, {31'd0, b[i]});
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_miso", {31'd0, bus.MISO}, 32'd0);
        chk("async_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
        chk("async_rd_addr", {31'd0, dut.rd_addr_received}, 32'd0);
        chk("async_state", {29'd0, dut.state}, 32'd0);
        bus.SS_n = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("post_rst_idle", {29'd0, dut.state}, 32'd0);
        chk("post_rst_miso", {31'd0, bus.MISO}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
